// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per clock.
//
// Operands are accepted on an in_valid/in_ready handshake, converted to magnitudes
// (when SIGNED), divided over WIDTH step cycles, sign-corrected and presented on
// an out_valid/out_ready handshake. Only one operation is in flight at a time.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over everything)
//   in_valid     dividend/divisor present
//   in_ready     block can accept operands (high only in idle)
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   out_valid    result present
//   out_ready    consumer takes result
//   quotient     result quotient, WIDTH bits
//   remainder    result remainder, WIDTH bits
//   div_by_zero  divide-by-zero flag, qualified by out_valid
//
// Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
// Signed mode truncates toward zero; the remainder takes the dividend's sign.
// -2^(WIDTH-1) / -1 wraps to quotient -2^(WIDTH-1), remainder 0.

module seq_divider #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Partial remainder, one bit wider than the operands so that the shifted
  // value never overflows before the compare.
  logic [WIDTH:0]    p_q, p_d;
  // Dividend magnitude; quotient bits shift in from the LSB as dividend bits
  // shift out of the MSB, so this ends up holding the quotient magnitude.
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dsr_q, dsr_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  // ---------------------------------------------------------------------------
  // Operand magnitude conversion (load time)
  // ---------------------------------------------------------------------------
  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in WIDTH
  // unsigned bits; the WIDTH+1-bit partial remainder carries it through the
  // subtract without loss.
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;

  always_comb begin
    dvd_neg = SIGNED && dividend[WIDTH-1];
    dsr_neg = SIGNED && divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    dsr_mag = dsr_neg ? (~divisor + WIDTH'(1)) : divisor;
  end

  // ---------------------------------------------------------------------------
  // One restoring step: trial subtract through a ripple chain of full adders
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH+1:0] sub_carry;
  logic             no_borrow;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  always_comb begin
    p_shift      = {p_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    // a - b computed as a + ~b + 1; carry out set means a >= b.
    sub_b        = ~{1'b0, dsr_q};
    sub_sum      = '0;
    sub_carry    = '0;
    sub_carry[0] = 1'b1;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      sub_sum[i]     = p_shift[i] ^ sub_b[i] ^ sub_carry[i];
      sub_carry[i+1] = (p_shift[i] & sub_b[i]) |
                       (sub_carry[i] & (p_shift[i] ^ sub_b[i]));
    end
    no_borrow = sub_carry[WIDTH+1];
    p_step    = no_borrow ? sub_sum : p_shift;
    q_step    = {dvd_q[WIDTH-2:0], no_borrow};

    // Sign correction applied on the last step. The remainder magnitude is
    // always below the divisor magnitude, so the low WIDTH bits are exact.
    quo_fin = neg_quo_q ? (~q_step + WIDTH'(1)) : q_step;
    rem_fin = neg_rem_q ? (~p_step[WIDTH-1:0] + WIDTH'(1)) : p_step[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            p_d       = '0;
            dvd_d     = dvd_mag;
            dsr_d     = dsr_mag;
            neg_quo_d = dvd_neg ^ dsr_neg;
            neg_rem_d = dvd_neg;
            cnt_d     = '0;
            state_d   = StCalc;
          end
        end
      end

      StCalc: begin
        p_d   = p_step;
        dvd_d = q_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          quo_d   = quo_fin;
          rem_d   = rem_fin;
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        // Return to idle only; in_ready rises the following cycle.
        if (out_ready) begin
          dbz_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_q       <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8). A signed and an unsigned
// instance share all inputs so each vector checks both interpretations.

module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_ready;

  logic       in_ready_s, out_valid_s, dbz_s;
  logic [7:0] quotient_s, remainder_s;
  logic       in_ready_u, out_valid_u, dbz_u;
  logic [7:0] quotient_u, remainder_u;

  int errors;
  int checks;

  seq_divider #(
    .WIDTH  (8),
    .SIGNED (1'b1)
  ) u_dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid_s),
    .out_ready   (out_ready),
    .quotient    (quotient_s),
    .remainder   (remainder_s),
    .div_by_zero (dbz_s)
  );

  seq_divider #(
    .WIDTH  (8),
    .SIGNED (1'b0)
  ) u_dut_u (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready_u),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid_u),
    .out_ready   (out_ready),
    .quotient    (quotient_u),
    .remainder   (remainder_u),
    .div_by_zero (dbz_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] qs;
    logic [7:0] rs;
    logic [7:0] qu;
    logic [7:0] ru;
    logic       dbz;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation with out_ready held high. Called at posedge+1 in idle.
  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] qs, input logic [7:0] rs,
                       input logic [7:0] qu, input logic [7:0] ru, input logic dbz);
    int n;
    bit busy_rdy;
    chk($sformatf("%s.idle_in_ready", nm), {31'd0, in_ready_s}, 32'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    // Operands must only matter at the accept edge.
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n        = 1;
    busy_rdy = 1'b0;
    while (!out_valid_s && n < 40) begin
      if (in_ready_s || in_ready_u) busy_rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready_s || in_ready_u) busy_rdy = 1'b1;
    chk($sformatf("%s.latency", nm), n, dbz ? 32'd1 : 32'd9);
    chk($sformatf("%s.busy_in_ready", nm), {31'd0, busy_rdy}, 32'd0);
    chk($sformatf("%s.out_valid_u", nm), {31'd0, out_valid_u}, 32'd1);
    chk($sformatf("%s.quo_s", nm), {24'd0, quotient_s}, {24'd0, qs});
    chk($sformatf("%s.rem_s", nm), {24'd0, remainder_s}, {24'd0, rs});
    chk($sformatf("%s.quo_u", nm), {24'd0, quotient_u}, {24'd0, qu});
    chk($sformatf("%s.rem_u", nm), {24'd0, remainder_u}, {24'd0, ru});
    chk($sformatf("%s.dbz_s", nm), {31'd0, dbz_s}, {31'd0, dbz});
    chk($sformatf("%s.dbz_u", nm), {31'd0, dbz_u}, {31'd0, dbz});
    @(posedge clk); #1;
    chk($sformatf("%s.post_out_valid", nm), {31'd0, out_valid_s}, 32'd0);
    chk($sformatf("%s.post_in_ready", nm), {31'd0, in_ready_s}, 32'd1);
    chk($sformatf("%s.post_dbz", nm), {31'd0, dbz_s}, 32'd0);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    //            name          a      b      q_s    r_s    q_u    r_u    dbz
    vecs[0]  = '{"100/7",     8'h64, 8'h07, 8'h0E, 8'h02, 8'h0E, 8'h02, 1'b0};
    vecs[1]  = '{"-100/7",    8'h9C, 8'h07, 8'hF2, 8'hFE, 8'h16, 8'h02, 1'b0};
    vecs[2]  = '{"100/-7",    8'h64, 8'hF9, 8'hF2, 8'h02, 8'h00, 8'h64, 1'b0};
    vecs[3]  = '{"100/0",     8'h64, 8'h00, 8'hFF, 8'h64, 8'hFF, 8'h64, 1'b1};
    vecs[4]  = '{"5/1",       8'h05, 8'h01, 8'h05, 8'h00, 8'h05, 8'h00, 1'b0};
    vecs[5]  = '{"-128/-1",   8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0};
    vecs[6]  = '{"255/16",    8'hFF, 8'h10, 8'h00, 8'hFF, 8'h0F, 8'h0F, 1'b0};
    vecs[7]  = '{"-7/-2",     8'hF9, 8'hFE, 8'h03, 8'hFF, 8'h00, 8'hF9, 1'b0};
    vecs[8]  = '{"-128/1",    8'h80, 8'h01, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};
    vecs[9]  = '{"50/5",      8'h32, 8'h05, 8'h0A, 8'h00, 8'h0A, 8'h00, 1'b0};
    vecs[10] = '{"127/-128",  8'h7F, 8'h80, 8'h00, 8'h7F, 8'h00, 8'h7F, 1'b0};
    vecs[11] = '{"-1/-1",     8'hFF, 8'hFF, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", {31'd0, in_ready_s}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("reset.quotient", {24'd0, quotient_s}, 32'd0);
    chk("reset.remainder", {24'd0, remainder_s}, 32'd0);
    chk("reset.dbz", {31'd0, dbz_s}, 32'd0);
    chk("reset.in_ready_u", {31'd0, in_ready_u}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].qs, vecs[i].rs,
            vecs[i].qu, vecs[i].ru, vecs[i].dbz);
    end

    // Backpressure: result held while out_ready is low, in_valid ignored.
    out_ready = 1'b0;
    dividend  = 8'd100;
    divisor   = 8'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp.latency", n, 32'd9);
    in_valid = 1'b1;
    dividend = 8'd5;
    divisor  = 8'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.out_valid", c), {31'd0, out_valid_s}, 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", c), {31'd0, in_ready_s}, 32'd0);
      chk($sformatf("bp.hold%0d.quo", c), {24'd0, quotient_s}, 32'h0E);
      chk($sformatf("bp.hold%0d.rem", c), {24'd0, remainder_s}, 32'h02);
    end
    // in_valid stays high across the release edge: no same-cycle accept.
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release.out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("bp.release.in_ready", {31'd0, in_ready_s}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp.idle.in_ready", {31'd0, in_ready_s}, 32'd1);

    // Reset during the third CALC cycle discards the operation.
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.in_ready", {31'd0, in_ready_s}, 32'd1);
    chk("midrst.out_valid", {31'd0, out_valid_s}, 32'd0);
    chk("midrst.quotient", {24'd0, quotient_s}, 32'd0);
    chk("midrst.remainder", {24'd0, remainder_s}, 32'd0);
    chk("midrst.out_valid_u", {31'd0, out_valid_u}, 32'd0);
    rst = 1'b0;
    do_op("after_rst_50/5", 8'd50, 8'd5, 8'h0A, 8'h00, 8'h0A, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
